// File: rtl/detector_flanco_multi.sv
// Multi-channel edge detector: per-channel synchroniser, debounce filter, mode-selectable
// edge pulse and sticky pending flag, plus a shared saturating event counter and IRQ.
module detector_flanco_multi #(
    parameter int unsigned N_CANALES       = 4,
    parameter int unsigned SYNC_ETAPAS     = 2,
    parameter int unsigned DEBOUNCE_CICLOS = 1,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CANALES-1:0]   senal_entrada,
    input  logic [2*N_CANALES-1:0] modo,
    input  logic [N_CANALES-1:0]   limpiar,
    input  logic                   limpiar_cnt,
    output logic [N_CANALES-1:0]   nivel_filtrado,
    output logic [N_CANALES-1:0]   pulso,
    output logic [N_CANALES-1:0]   pendiente,
    output logic                   irq,
    output logic [CNT_W-1:0]       contador_eventos
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CICLOS) + 1;
    localparam int unsigned PW = $clog2(N_CANALES + 1);
    localparam int unsigned EW = CNT_W + PW + 1;

    logic [N_CANALES-1:0] sync_out;
    logic [N_CANALES-1:0] nivel_q, nivel_d;
    logic [N_CANALES-1:0] pulso_q, pulso_d;
    logic [N_CANALES-1:0] pend_q, pend_d;
    logic                 irq_q;
    logic [CNT_W-1:0]     cnt_ev_q, cnt_ev_d;
    logic [PW-1:0]        parcial [N_CANALES+1];
    logic [EW-1:0]        suma;

    assign parcial[0] = '0;

    genvar g;
    generate
        for (g = 0; g < N_CANALES; g++) begin : g_canal
            logic [DW-1:0] cnt_q, cnt_d;
            logic          conmuta;
            logic          sube, baja;

            if (SYNC_ETAPAS == 0) begin : g_directo
                assign sync_out[g] = senal_entrada[g];
            end else begin : g_sinc
                logic [SYNC_ETAPAS-1:0] sinc_q;
                // Shift toward the MSB; the MSB is the last (most settled) stage.
                always_ff @(posedge clk) begin
                    if (!rst_n) sinc_q <= '0;
                    else        sinc_q <= SYNC_ETAPAS'({sinc_q, senal_entrada[g]});
                end
                assign sync_out[g] = sinc_q[SYNC_ETAPAS-1];
            end

            always_comb begin
                conmuta = 1'b0;
                cnt_d   = cnt_q;
                if (sync_out[g] == nivel_q[g]) begin
                    cnt_d = '0;
                end else if (cnt_q == DW'(DEBOUNCE_CICLOS - 1)) begin
                    conmuta = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end

            assign nivel_d[g]   = nivel_q[g] ^ conmuta;
            assign sube         = conmuta & ~nivel_q[g];
            assign baja         = conmuta &  nivel_q[g];
            assign pulso_d[g]   = (sube & modo[2*g]) | (baja & modo[2*g+1]);
            assign parcial[g+1] = parcial[g] + PW'(pulso_d[g]);
        end
    endgenerate

    // A clear coinciding with a new pulse keeps the flag set so no event is lost.
    assign pend_d = pulso_d | (pend_q & ~limpiar);

    always_comb begin
        suma = (limpiar_cnt ? '0 : EW'(cnt_ev_q)) + EW'(parcial[N_CANALES]);
        if (|suma[EW-1:CNT_W]) cnt_ev_d = '1;
        else                   cnt_ev_d = suma[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nivel_q  <= '0;
            pulso_q  <= '0;
            pend_q   <= '0;
            irq_q    <= 1'b0;
            cnt_ev_q <= '0;
        end else begin
            nivel_q  <= nivel_d;
            pulso_q  <= pulso_d;
            pend_q   <= pend_d;
            irq_q    <= |pend_q;
            cnt_ev_q <= cnt_ev_d;
        end
    end

    assign nivel_filtrado   = nivel_q;
    assign pulso            = pulso_q;
    assign pendiente        = pend_q;
    assign irq              = irq_q;
    assign contador_eventos = cnt_ev_q;

endmodule

// File: tb/tb_detector_flanco_multi.sv
// Bench for detector_flanco_multi (4 channels, 2 sync stages, 4-cycle debounce, 8-bit counter):
// a cycle model feeds a scoreboard queue, plus directed checks on latency, glitches and saturation.
module tb_detector_flanco_multi;

    localparam int unsigned DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] senal_entrada;
    logic [7:0] modo;
    logic [3:0] limpiar;
    logic       limpiar_cnt;
    logic [3:0] nivel_filtrado;
    logic [3:0] pulso;
    logic [3:0] pendiente;
    logic       irq;
    logic [7:0] contador_eventos;

    detector_flanco_multi #(
        .N_CANALES(4),
        .SYNC_ETAPAS(2),
        .DEBOUNCE_CICLOS(DEB),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .senal_entrada(senal_entrada),
        .modo(modo),
        .limpiar(limpiar),
        .limpiar_cnt(limpiar_cnt),
        .nivel_filtrado(nivel_filtrado),
        .pulso(pulso),
        .pendiente(pendiente),
        .irq(irq),
        .contador_eventos(contador_eventos)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [3:0]    lvl;
        bit [3:0]    pul;
        bit [3:0]    pend;
        bit          irq;
        int unsigned cnt;
    } esperado_t;

    esperado_t   sb[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Stimulus applied by the next ciclo() call
    bit [3:0] cur_in  = '0;
    bit [7:0] cur_md  = '0;
    bit [3:0] cur_lp  = '0;
    bit       cur_lc  = 1'b0;
    bit       cur_rst = 1'b0;

    // Reference model state
    bit [3:0]    m_s1, m_s2, m_lvl, m_pul, m_pend;
    bit          m_irq;
    int unsigned m_cnt;
    int unsigned m_run [4];
    int unsigned seen [4];

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void filtro(input bit s, input bit l, inout int unsigned run, output bit nl);
        nl = l;
        if (s != l) begin
            run++;
            if (run == DEB) begin
                nl  = ~l;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endfunction

    task automatic ciclo();
        esperado_t   e;
        bit [3:0]    nl, ed, re_en, fe_en, pl;
        int unsigned pop, sum;
        @(negedge clk);
        senal_entrada = cur_in;
        modo          = cur_md;
        limpiar       = cur_lp;
        limpiar_cnt   = cur_lc;
        rst_n         = cur_rst;
        if (!cur_rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pul = '0; m_pend = '0;
            m_irq = 1'b0; m_cnt = 0;
            m_run[0] = 0; m_run[1] = 0; m_run[2] = 0; m_run[3] = 0;
        end else begin
            filtro(m_s2[0], m_lvl[0], m_run[0], nl[0]);
            filtro(m_s2[1], m_lvl[1], m_run[1], nl[1]);
            filtro(m_s2[2], m_lvl[2], m_run[2], nl[2]);
            filtro(m_s2[3], m_lvl[3], m_run[3], nl[3]);
            ed    = nl ^ m_lvl;
            re_en = {cur_md[6], cur_md[4], cur_md[2], cur_md[0]};
            fe_en = {cur_md[7], cur_md[5], cur_md[3], cur_md[1]};
            pl    = (ed & nl & re_en) | (ed & m_lvl & fe_en);
            pop   = $countones(pl);
            sum   = m_cnt + pop;
            m_irq  = |m_pend;
            m_pend = pl | (m_pend & ~cur_lp);
            m_cnt  = cur_lc ? pop : ((sum > 255) ? 255 : sum);
            m_pul  = pl;
            m_lvl  = nl;
            m_s2   = m_s1;
            m_s1   = cur_in;
        end
        e.lvl = m_lvl; e.pul = m_pul; e.pend = m_pend; e.irq = m_irq; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("nivel",     32'(nivel_filtrado),   32'(e.lvl));
        chk("pulso",     32'(pulso),            32'(e.pul));
        chk("pendiente", 32'(pendiente),        32'(e.pend));
        chk("irq",       32'(irq),              32'(e.irq));
        chk("contador",  32'(contador_eventos), e.cnt);
        seen[0] += 32'(pulso[0]);
        seen[1] += 32'(pulso[1]);
        seen[2] += 32'(pulso[2]);
        seen[3] += 32'(pulso[3]);
    endtask

    task automatic ciclos(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) ciclo();
    endtask

    task automatic borrar_vistos();
        seen[0] = 0; seen[1] = 0; seen[2] = 0; seen[3] = 0;
    endtask

    initial begin
        int unsigned lat;
        senal_entrada = '0; modo = '0; limpiar = '0; limpiar_cnt = 1'b0; rst_n = 1'b0;

        // Reset for 3 cycles, then release with all channels on rising mode
        cur_rst = 1'b0;
        ciclos(3);
        chk("reset_cnt", 32'(contador_eventos), 0);
        cur_rst = 1'b1;
        cur_md  = 8'h55;
        ciclos(2);

        // Rising edge latency on channel 0
        borrar_vistos();
        cur_in = 4'b0001;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            ciclo();
            lat++;
            if (pulso[0]) break;
        end
        chk("t1_latencia", lat, 6);
        ciclo();
        chk("t1_pend", 32'(pendiente[0]), 1);
        chk("t1_irq", 32'(irq), 1);
        chk("t1_cnt", 32'(contador_eventos), 1);
        ciclos(4);

        // Glitch rejection on channel 1, then an accepted level
        borrar_vistos();
        cur_in[1] = 1'b1; ciclos(2);
        cur_in[1] = 1'b0; ciclos(8);
        chk("t2_glitch_pulsos", seen[1], 0);
        chk("t2_glitch_nivel", 32'(nivel_filtrado[1]), 0);
        cur_in[1] = 1'b1; ciclos(10);
        chk("t2_nivel", 32'(nivel_filtrado[1]), 1);
        chk("t2_pulsos", seen[1], 1);

        // Channel 2 modes: both, falling, off
        cur_md = 8'h75; borrar_vistos();
        cur_in[2] = 1'b1; ciclos(10);
        cur_in[2] = 1'b0; ciclos(10);
        chk("t3_ambos", seen[2], 2);
        cur_md = 8'h65; borrar_vistos();
        cur_in[2] = 1'b1; ciclos(10);
        chk("t3_bajada_sin_subida", seen[2], 0);
        cur_in[2] = 1'b0; ciclos(10);
        chk("t3_bajada", seen[2], 1);
        cur_md = 8'h45; borrar_vistos();
        cur_in[2] = 1'b1; ciclos(10);
        chk("t3_off_nivel1", 32'(nivel_filtrado[2]), 1);
        cur_in[2] = 1'b0; ciclos(10);
        chk("t3_off_nivel0", 32'(nivel_filtrado[2]), 0);
        chk("t3_off_pulsos", seen[2], 0);

        // All four channels rising together
        cur_md = 8'h55;
        cur_in = '0; ciclos(8);
        cur_in = 4'hF;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            ciclo();
            lat++;
            if (pulso != 4'h0) break;
        end
        chk("t4_todos", 32'(pulso), 32'hF);
        ciclos(3);

        // Counter saturation: clear, reach 252, then 254, then saturate at 255
        cur_lc = 1'b1; ciclo(); cur_lc = 1'b0;
        chk("t4_cnt_limpio", 32'(contador_eventos), 0);
        cur_md = 8'hFF;
        for (int i = 0; i < 63; i++) begin
            cur_in = ~cur_in;
            ciclos(7);
        end
        chk("t4_cnt_252", 32'(contador_eventos), 252);
        cur_md = 8'h0F; cur_in = ~cur_in; ciclos(7);
        chk("t4_cnt_254", 32'(contador_eventos), 254);
        cur_md = 8'hFF; cur_in = ~cur_in; ciclos(7);
        chk("t4_cnt_sat", 32'(contador_eventos), 255);
        cur_in = ~cur_in; ciclos(7);
        chk("t4_cnt_sat_sigue", 32'(contador_eventos), 255);

        // Clear coinciding with a new pulse keeps pendiente set
        cur_md = 8'h55;
        cur_in = '0; ciclos(8);
        cur_lp = 4'hF; ciclo(); cur_lp = '0;
        cur_in = 4'b0001; ciclos(5);
        cur_lp[0] = 1'b1; ciclo();
        chk("t5_pulso", 32'(pulso[0]), 1);
        chk("t5_pend_set", 32'(pendiente[0]), 1);
        ciclo();
        chk("t5_pend_clr", 32'(pendiente[0]), 0);
        cur_lp = '0;
        ciclos(3);

        // Input held high through reset yields one rising pulse
        cur_rst = 1'b0; ciclos(3);
        cur_rst = 1'b1; borrar_vistos();
        ciclos(12);
        chk("t6_pulso_tras_reset", seen[0], 1);
        chk("t6_otros", seen[1] + seen[2] + seen[3], 0);

        // Reset in the middle of a debounce restarts it
        cur_in = 4'b0011; ciclos(3);
        cur_rst = 1'b0; ciclo();
        chk("t6_rst_pulso", 32'(pulso), 0);
        chk("t6_rst_pend", 32'(pendiente), 0);
        chk("t6_rst_nivel", 32'(nivel_filtrado), 0);
        chk("t6_rst_cnt", 32'(contador_eventos), 0);
        cur_rst = 1'b1;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            ciclo();
            lat++;
            if (pulso[1]) break;
        end
        chk("t6_latencia", lat, 6);
        ciclos(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
